// File: rtl/bnn_param_loader.sv
// bnn_param_loader: buffers a host-written parameter image and streams it LSB-first into the BNN chain.
// Latency: start accepted at edge t -> setup high from t+1 for CHAIN_BITS cycles (x2 with verify), done pulse after.
// Backpressure: wr_ready low when buffer full or not IDLE; bytes, flush and start are ignored outside IDLE.
// Optional feature macro: BNN_PARAM_VERIFY_EN adds a replay pass that checks param_ret into sticky verify_err.
module bnn_param_loader #(
  parameter int NEURONS     = 8,
  parameter int NEURON_BITS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       flush,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       setup,
  output logic       param_out,
  input  logic       param_ret,
  output logic       verify_err
);

  localparam int CHAIN_BITS = NEURONS * NEURON_BITS;
  localparam int WORDS      = (CHAIN_BITS + 7) / 8;
  localparam int BW         = $clog2(CHAIN_BITS);
  localparam int IW         = $clog2(WORDS * 8);
  localparam int FW         = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic                setup_q, setup_d;
  logic                param_out_q, param_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                verr_q, verr_d;
  logic [WORDS*8-1:0]  img_q, img_d;

  logic                full;
  logic                wr_fire;
  logic                last_bit;
  logic [IW-1:0]       cur_idx;
  logic [IW-1:0]       nxt_idx;
  logic [IW-1:0]       wr_idx;

`ifndef BNN_PARAM_VERIFY_EN
  // The readback pin only matters when the replay pass exists.
  logic unused_param_ret;
  assign unused_param_ret = param_ret;
`endif

  assign full     = (fill_q == FW'(WORDS));
  assign wr_ready = (state_q == IDLE) && !full;
  // A simultaneous flush discards the byte so the refilled image starts clean.
  assign wr_fire  = wr_valid && wr_ready && !flush;
  assign last_bit = (bitcnt_q == BW'(CHAIN_BITS - 1));
  assign cur_idx  = IW'(bitcnt_q);
  assign nxt_idx  = IW'(bitcnt_q + BW'(1));
  assign wr_idx   = IW'({fill_q, 3'b000});

  // Image buffer: host bytes land at the current fill position.
  always_comb begin
    img_d = img_q;
    if (wr_fire) img_d[wr_idx +: 8] = wr_data;
  end

  // Next-state and registered-output decode; outputs are precomputed so they change on the same edge as state.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    bitcnt_d    = bitcnt_q;
    setup_d     = 1'b0;
    param_out_d = 1'b0;
    done_d      = 1'b0;
    verr_d      = verr_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          fill_d = '0;
        end else begin
          if (wr_fire) fill_d = fill_q + FW'(1);
          if (start && full) begin
            state_d     = SHIFT;
            bitcnt_d    = '0;
            setup_d     = 1'b1;
            param_out_d = img_q[0];
            verr_d      = 1'b0;
          end
        end
      end
      SHIFT: begin
        setup_d = 1'b1;
        if (last_bit) begin
`ifdef BNN_PARAM_VERIFY_EN
          state_d     = VERIFY;
          bitcnt_d    = '0;
          param_out_d = img_q[0];
`else
          state_d = DONE;
          setup_d = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          bitcnt_d    = bitcnt_q + BW'(1);
          param_out_d = img_q[nxt_idx];
        end
      end
`ifdef BNN_PARAM_VERIFY_EN
      VERIFY: begin
        setup_d = 1'b1;
        // The chain's tail emits bit j while replay bit j is being driven in.
        if (param_ret != img_q[cur_idx]) verr_d = 1'b1;
        if (last_bit) begin
          state_d = DONE;
          setup_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          bitcnt_d    = bitcnt_q + BW'(1);
          param_out_d = img_q[nxt_idx];
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT) || (state_d == VERIFY);
  end

  // Control state register with synchronous reset; reset leaves the image invalid (fill=0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      bitcnt_q    <= '0;
      setup_q     <= 1'b0;
      param_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      verr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      bitcnt_q    <= bitcnt_d;
      setup_q     <= setup_d;
      param_out_q <= param_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      verr_q      <= verr_d;
    end
  end

  // Image storage needs no reset: fill_q gates whether it is valid.
  always_ff @(posedge clk) begin
    img_q <= img_d;
  end

  assign setup      = setup_q;
  assign param_out  = param_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign verify_err = verr_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: random images, 96-stage chain model, timing and protocol checks.
module tb_bnn_param_loader;

  localparam int CB = 96;
  localparam int NW = 12;
`ifdef BNN_PARAM_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam logic [CB-1:0] FLIP40 = CB'(1) << 40;

  logic       clk = 1'b0;
  logic       reset, wr_valid, flush, start, param_ret;
  logic [7:0] wr_data;
  logic       wr_ready, busy, done, setup, param_out, verify_err;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned model_img [NW];
  int           model_fill = 0;

  logic [CB-1:0] chain = '0;
  int            chain_cnt = 0;
  logic          inject = 1'b0;

  bnn_param_loader dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .start(start), .busy(busy), .done(done), .setup(setup),
    .param_out(param_out), .param_ret(param_ret), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  // Chain model: bit shifted in first ends up at index 0, which is the tail output.
  always @(posedge clk) begin
    if (setup) begin
      chain_cnt <= chain_cnt + 1;
      if (inject && chain_cnt == CB - 1) chain <= {param_out, chain[CB-1:1]} ^ FLIP40;
      else                               chain <= {param_out, chain[CB-1:1]};
    end else begin
      chain_cnt <= 0;
    end
  end
  assign param_ret = chain[0];

  function automatic logic [CB-1:0] exp_bits();
    logic [CB-1:0] v;
    for (int k = 0; k < CB; k++) v[k] = model_img[k/8][k%8];
    return v;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge clk);
    if (model_fill < NW) begin
      model_img[model_fill] = b;
      model_fill++;
    end
    #1 wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collects one stream; cycle c is the sample after the c-th edge following start acceptance.
  task automatic run_stream(output int su_cnt, output int dn_idx, output int dn_cnt,
                            output logic [CB-1:0] bits, output logic setup0,
                            output logic busy_at_done, output logic verr0);
    su_cnt = 0; dn_idx = -1; dn_cnt = 0; bits = '0; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    setup0 = setup;
    verr0  = verify_err;
    for (int c = 0; c < 2 * CB + 20; c++) begin
      if (setup) su_cnt++;
      if (c < CB) bits[c] = param_out;
      if (done) begin
        dn_cnt++;
        if (dn_idx < 0) begin
          dn_idx = c;
          busy_at_done = busy;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({setup, param_out, busy, done, verify_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000", {setup, param_out, busy, done, verify_err});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_write_fill();
    logic [7:0] b;
    for (int i = 0; i < NW; i++) begin
      b = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'($urandom);
      write_byte(b);
      @(negedge clk);
      if (i == NW - 2) begin
        n_cmp++;
        if (wr_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL ready_before_full: got %b want 1", wr_ready);
        end
      end
    end
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_when_full: got %b want 0", wr_ready);
    end
    write_byte(8'hFF);
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_extra: got %b want 0", wr_ready);
    end
  endtask

  task automatic test_stream();
    int su, di, dc;
    logic [CB-1:0] bits, exp;
    logic s0, bd, v0;
    exp = exp_bits();
    run_stream(su, di, dc, bits, s0, bd, v0);
    n_cmp++;
    if (s0 !== 1'b1) begin n_bad++; $display("FAIL stream_first_setup: got %b want 1", s0); end
    n_cmp++;
    if (su != CB * PASSES) begin n_bad++; $display("FAIL stream_setup_cycles: got %0d want %0d", su, CB * PASSES); end
    n_cmp++;
    if (di != CB * PASSES) begin n_bad++; $display("FAIL stream_done_latency: got %0d want %0d", di, CB * PASSES); end
    n_cmp++;
    if (dc != 1) begin n_bad++; $display("FAIL stream_done_count: got %0d want 1", dc); end
    n_cmp++;
    if (bits !== exp) begin n_bad++; $display("FAIL stream_bits: got %h want %h", bits, exp); end
    n_cmp++;
    if (chain !== exp) begin n_bad++; $display("FAIL chain_contents: got %h want %h", chain, exp); end
    n_cmp++;
    if (bd !== 1'b0) begin n_bad++; $display("FAIL busy_in_done: got %b want 0", bd); end
    n_cmp++;
    if (verify_err !== 1'b0) begin n_bad++; $display("FAIL stream_verify_err: got %b want 0", verify_err); end
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL fill_kept: wr_ready got %b want 0", wr_ready); end
  endtask

  task automatic test_back_to_back();
    int su, di, dc;
    logic [CB-1:0] bits, exp;
    logic s0, bd, v0;
    exp = exp_bits();
    for (int r = 0; r < 2; r++) begin
      run_stream(su, di, dc, bits, s0, bd, v0);
      n_cmp++;
      if (bits !== exp || di != CB * PASSES) begin
        n_bad++;
        $display("FAIL b2b_restream%0d: got bits %h done@%0d want %h done@%0d", r, bits, di, exp, CB * PASSES);
      end
    end
  endtask

`ifdef BNN_PARAM_VERIFY_EN
  task automatic test_verify();
    int su, di, dc;
    logic [CB-1:0] bits, exp;
    logic s0, bd, v0;
    exp = exp_bits();
    inject = 1'b1;
    run_stream(su, di, dc, bits, s0, bd, v0);
    inject = 1'b0;
    n_cmp++;
    if (verify_err !== 1'b1) begin n_bad++; $display("FAIL verify_err_set: got %b want 1", verify_err); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (verify_err !== 1'b1) begin n_bad++; $display("FAIL verify_err_sticky: got %b want 1", verify_err); end
    n_cmp++;
    if (chain !== exp) begin n_bad++; $display("FAIL verify_chain_restored: got %h want %h", chain, exp); end
    run_stream(su, di, dc, bits, s0, bd, v0);
    n_cmp++;
    if (v0 !== 1'b0) begin n_bad++; $display("FAIL verify_err_clear_on_start: got %b want 0", v0); end
    n_cmp++;
    if (verify_err !== 1'b0) begin n_bad++; $display("FAIL verify_clean_pass: got %b want 0", verify_err); end
  endtask
`endif

  task automatic test_ignored_start();
    int su, di, dc;
    logic [CB-1:0] bits, exp;
    logic s0, bd, v0;
    logic any_busy;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    model_fill = 0;
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", wr_ready); end
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    pulse_start();
    any_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      any_busy |= busy | setup;
      @(negedge clk);
    end
    n_cmp++;
    if (any_busy !== 1'b0) begin n_bad++; $display("FAIL partial_start_ignored: busy/setup got %b want 0", any_busy); end
    for (int i = 0; i < NW - 5; i++) write_byte(8'($urandom));
    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    model_fill = 0;
    n_cmp++;
    if ({busy, setup, wr_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL flush_beats_start: busy,setup,ready got %b want 001", {busy, setup, wr_ready});
    end
    for (int i = 0; i < NW; i++) write_byte(8'($urandom));
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL refill_full: got %b want 0", wr_ready); end
    exp = exp_bits();
    run_stream(su, di, dc, bits, s0, bd, v0);
    n_cmp++;
    if (bits !== exp) begin n_bad++; $display("FAIL refill_stream: got %h want %h", bits, exp); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    int setup_seen = 0;
    pulse_start();
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({setup, busy, wr_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_reset_drop: setup,busy,ready got %b want 001", {setup, busy, wr_ready});
    end
    reset = 1'b0;
    model_fill = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (setup) setup_seen++;
    end
    n_cmp++;
    if (done_seen != 0 || setup_seen != 0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: done %0d setup %0d want 0 0", done_seen, setup_seen);
    end
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({busy, wr_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_reset_empty: busy,ready got %b want 01", {busy, wr_ready});
    end
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_stream();
    test_back_to_back();
`ifdef BNN_PARAM_VERIFY_EN
    test_verify();
`endif
    test_ignored_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
